cpu_core_param: RTL and testbench
=================================

# cpu_core_param

Parametrised multi-cycle successor to the 8-bit single-cycle datapath. It owns the PC, register file, ALU, and a memory-access FSM. It executes the full 12-opcode ISA (loadi through swi) plus halt, on a configurable data width and register count. It sits between the instruction memory (combinational fetch on `PC`) and a data memory/cache that stalls through a busywait handshake.

## Interface
- `DATA_W`, default 8: datapath and register width; legal range 8..32.
- `NREGS`, default 8: register count; power of two, 2..256; index width `RA_W = clog2(NREGS)`.
- `PC_W`, default 32: PC width; word-addressed.
- `CLK` input 1: single clock; all state updates on rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `INSTRUCTION` input 32: instruction at `PC`, valid combinationally in the same cycle.
- `PC` output PC_W: current instruction address.
- `MEM_READ` output 1: data-memory read request.
- `MEM_WRITE` output 1: data-memory write request.
- `MEM_ADDR` output DATA_W: data-memory address.
- `MEM_WRITEDATA` output DATA_W: store data.
- `MEM_READDATA` input DATA_W: load data; valid in the cycle `MEM_BUSYWAIT` is 0.
- `MEM_BUSYWAIT` input 1: memory stall.
- `HALTED` output 1: core stopped.

## Operation
- Fields:
  - opcode = `INSTRUCTION[31:24]`
  - rd/offset = `[23:16]`
  - rs1 = `[15:8]`
  - rs2/imm = `[7:0]`
  - Register indices use the low `RA_W` bits of their field; upper bits are ignored.
- imm and offset are sign-extended: imm to DATA_W, offset to PC_W.
- Opcodes:
  - 0x00 loadi: rd=imm
  - 0x01 mov: rd=rs2
  - 0x02 add: rd=rs1+rs2
  - 0x03 sub: rd=rs1-rs2, implemented as two's-complement add
  - 0x04 and; 0x05 or
  - 0x06 j: PC=PC+1+offset
  - 0x07 beq: if rs1==rs2 then PC=PC+1+offset, else PC+1
  - 0x08 lwd: rd=M[rs2]
  - 0x09 lwi: rd=M[imm]
  - 0x0A swd: M[rs2]=rs1
  - 0x0B swi: M[imm]=rs1
  - 0x0C halt
  - Any other opcode: NOP, PC+1.
- Arithmetic is modulo 2^DATA_W; carry and overflow are discarded. PC arithmetic is modulo 2^PC_W.
- FSM states:
  - EXEC: decode the instruction.
    - ALU, loadi, mov: write rd and set PC+1 at the cycle end; stay in EXEC.
    - j, beq, NOP: update PC; stay in EXEC.
    - lwd, lwi: go to MEM_RD. swd, swi: go to MEM_WR. PC is not updated on leaving EXEC.
    - halt: go to HALT; PC is not updated.
  - MEM_RD: `MEM_READ`=1, `MEM_ADDR` = effective address. While `MEM_BUSYWAIT`=1, hold. On the first edge with `MEM_BUSYWAIT`=0: rd = `MEM_READDATA`, PC+1, go to EXEC.
  - MEM_WR: `MEM_WRITE`=1, `MEM_ADDR`, `MEM_WRITEDATA`=rs1. Same completion rule as MEM_RD; no register write.
  - HALT: terminal. `HALTED`=1; PC frozen; no memory requests. Exit only via `RESET`.
- Effective address and store data are captured into registers on leaving EXEC. They are held stable for the whole MEM state even if register contents would change.
- `MEM_READ` and `MEM_WRITE` are never asserted together. Both are 0 outside the MEM states.
- The register file has no hardwired zero register; r0 is writable.

## Timing
- Reset (`RESET`=0, asynchronous):
  - PC=0, all registers=0, state=EXEC.
  - `MEM_READ`=`MEM_WRITE`=0, `MEM_ADDR`=0, `MEM_WRITEDATA`=0, `HALTED`=0.
- Reset release: the first instruction executes on the first rising edge after `RESET` goes high.
- Reset asserted mid-MEM state: the request drops immediately and no register write occurs.
- Latency:
  - Non-memory instructions: 1 cycle.
  - Loads and stores: 2 + N cycles, where N = number of sampled edges with `MEM_BUSYWAIT`=1.
  - `MEM_BUSYWAIT` is sampled only in MEM states; it is ignored in EXEC and HALT.
- Register write happens at the rising edge ending the instruction. The new value is visible to the next instruction's combinational read.
- A load's rd write and its PC+1 occur on the same edge.
- `MEM_*` outputs are registered: they assert on the edge entering the MEM state and deassert on the completion edge.
- beq compares the register values read in EXEC. rd == rs1 aliasing has no hazard, because all writes complete before the next decode.
- PC wrap: PC = 2^PC_W - 1 followed by PC+1 gives 0. A negative offset that wraps below 0 is taken modulo 2^PC_W.

## Test plan
- loadi r1,5 → loadi r2,3 → sub r3,r1,r2 → or r4,r1,r2: r3=2, r4=7, PC=4 after 4 cycles, no memory requests.
- DATA_W=8: loadi r1,0x7F → loadi r2,0x02 → add r5,r1,r2: r5=0x81. loadi r6,0xFF at DATA_W=16: r6=0xFFFF (sign extension).
- beq r1,r1,offset=0xFE at PC=10: PC becomes 9. beq on unequal operands: PC becomes 11. j with offset=3 at PC=0: PC becomes 4.
- swi r1,0x20 with r1=0xAA, `MEM_BUSYWAIT` held high 3 cycles: `MEM_WRITE`=1 for exactly 4 cycles, `MEM_ADDR`=0x20, `MEM_WRITEDATA`=0xAA; PC advances only on the completion edge.
- lwd r2,r7 with r7=0x10 and memory returning 0x5C after 2 busy cycles: r2=0x5C. Asserting `RESET` during the busy wait instead: `MEM_READ` drops immediately and r2 stays 0.
- halt at PC=3: `HALTED`=1, PC stays 3 for 20 cycles, no `MEM_READ`/`MEM_WRITE`. `RESET` pulse clears `HALTED` and sets PC=0.

Source files
------------

// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multi-cycle core with a PC, a register file,
// an ALU and a memory-access FSM (EXEC / MEM_RD / MEM_WR / HALT).
// The instruction is fetched combinationally at PC. Data memory stalls the
// core through MEM_BUSYWAIT. All memory-side outputs are registered.
module cpu_core_param #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  output logic [PC_W-1:0]   PC,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              HALTED
);

  localparam int RA_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [1:0] ST_EXEC   = 2'd0;
  localparam logic [1:0] ST_MEM_RD = 2'd1;
  localparam logic [1:0] ST_MEM_WR = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_HALT  = 8'h0C;

  // Architectural and FSM state
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [1:0]        state_q,     state_d;
  logic [PC_W-1:0]   pc_q,        pc_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              halted_q,    halted_d;
  logic [RA_W-1:0]   dest_q,      dest_d;

  // Decode and datapath
  logic [7:0]        opcode_s;
  logic [RA_W-1:0]   rd_idx_s;
  logic [RA_W-1:0]   rs1_idx_s;
  logic [RA_W-1:0]   rs2_idx_s;
  logic [DATA_W-1:0] rs1_val_s;
  logic [DATA_W-1:0] rs2_val_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic [PC_W-1:0]   off_ext_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic [PC_W-1:0]   pc_branch_s;
  logic              rf_we_s;
  logic [RA_W-1:0]   rf_waddr_s;
  logic [DATA_W-1:0] rf_wdata_s;
  logic              unused_fields_s;

  assign opcode_s    = INSTRUCTION[31:24];
  assign rd_idx_s    = INSTRUCTION[16 +: RA_W];
  assign rs1_idx_s   = INSTRUCTION[8 +: RA_W];
  assign rs2_idx_s   = INSTRUCTION[0 +: RA_W];
  assign rs1_val_s   = regs_q[rs1_idx_s];
  assign rs2_val_s   = regs_q[rs2_idx_s];
  assign imm_ext_s   = DATA_W'($signed(INSTRUCTION[7:0]));
  assign off_ext_s   = PC_W'($signed(INSTRUCTION[23:16]));
  assign pc_inc_s    = pc_q + PC_W'(1);
  assign pc_branch_s = pc_inc_s + off_ext_s;

  // Upper index bits are architecturally ignored.
  assign unused_fields_s = ^{INSTRUCTION[23:16], INSTRUCTION[15:8], INSTRUCTION[7:0]};

  assign PC            = pc_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDR      = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign HALTED        = halted_q;

  // Next-state logic: decode in EXEC, handshake in the MEM states.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    dest_d      = dest_q;
    rf_we_s     = 1'b0;
    rf_waddr_s  = rd_idx_s;
    rf_wdata_s  = {DATA_W{1'b0}};
    case (state_q)
      ST_EXEC: begin
        case (opcode_s)
          OP_LOADI: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = imm_ext_s;
            pc_d       = pc_inc_s;
          end
          OP_MOV: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = rs2_val_s;
            pc_d       = pc_inc_s;
          end
          OP_ADD: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = rs1_val_s + rs2_val_s;
            pc_d       = pc_inc_s;
          end
          OP_SUB: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = rs1_val_s + ~rs2_val_s + DATA_W'(1);
            pc_d       = pc_inc_s;
          end
          OP_AND: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = rs1_val_s & rs2_val_s;
            pc_d       = pc_inc_s;
          end
          OP_OR: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = rs1_val_s | rs2_val_s;
            pc_d       = pc_inc_s;
          end
          OP_J: begin
            pc_d = pc_branch_s;
          end
          OP_BEQ: begin
            if (rs1_val_s == rs2_val_s) begin
              pc_d = pc_branch_s;
            end else begin
              pc_d = pc_inc_s;
            end
          end
          OP_LWD: begin
            state_d    = ST_MEM_RD;
            mem_read_d = 1'b1;
            mem_addr_d = rs2_val_s;
            dest_d     = rd_idx_s;
          end
          OP_LWI: begin
            state_d    = ST_MEM_RD;
            mem_read_d = 1'b1;
            mem_addr_d = imm_ext_s;
            dest_d     = rd_idx_s;
          end
          OP_SWD: begin
            state_d     = ST_MEM_WR;
            mem_write_d = 1'b1;
            mem_addr_d  = rs2_val_s;
            mem_wdata_d = rs1_val_s;
          end
          OP_SWI: begin
            state_d     = ST_MEM_WR;
            mem_write_d = 1'b1;
            mem_addr_d  = imm_ext_s;
            mem_wdata_d = rs1_val_s;
          end
          OP_HALT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          default: begin
            pc_d = pc_inc_s;
          end
        endcase
      end
      ST_MEM_RD: begin
        if (!MEM_BUSYWAIT) begin
          rf_we_s    = 1'b1;
          rf_waddr_s = dest_q;
          rf_wdata_s = MEM_READDATA;
          pc_d       = pc_inc_s;
          mem_read_d = 1'b0;
          state_d    = ST_EXEC;
        end else begin
          state_d = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        if (!MEM_BUSYWAIT) begin
          pc_d        = pc_inc_s;
          mem_write_d = 1'b0;
          state_d     = ST_EXEC;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_HALT: begin
        state_d     = ST_HALT;
        halted_d    = 1'b1;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      default: begin
        state_d     = ST_EXEC;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        halted_d    = 1'b0;
      end
    endcase
  end

  // Control, PC and registered memory-interface state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_EXEC;
      pc_q        <= {PC_W{1'b0}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= {DATA_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      halted_q    <= 1'b0;
      dest_q      <= {RA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      dest_q      <= dest_d;
    end
  end

  // Register file: all entries clear on reset, one write port, r0 writable.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (rf_we_s) begin
      regs_q[rf_waddr_s] <= rf_wdata_s;
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Testbench for cpu_core_param: directed vector table, hand-written
// multi-cycle sequences, and randomized instructions against an
// instruction-level reference model.
module tb_cpu_core_param;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [7:0]  MEM_ADDR;
  logic [7:0]  MEM_WRITEDATA;
  logic [7:0]  MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic        HALTED;

  logic [31:0] instr16;
  logic [31:0] pc16;
  logic        rd16;
  logic        wr16;
  logic [15:0] addr16;
  logic [15:0] wdata16;
  logic [15:0] rdata16;
  logic        busy16;
  logic        halted16;

  int n_vec;
  int n_err;

  cpu_core_param #(.DATA_W(8), .NREGS(8), .PC_W(32)) u_dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .PC(PC),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .HALTED(HALTED)
  );

  cpu_core_param #(.DATA_W(16), .NREGS(8), .PC_W(32)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr16), .PC(pc16),
    .MEM_READ(rd16), .MEM_WRITE(wr16), .MEM_ADDR(addr16),
    .MEM_WRITEDATA(wdata16), .MEM_READDATA(rdata16),
    .MEM_BUSYWAIT(busy16), .HALTED(halted16)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    #1;
    chk("rst_pc", PC, 32'd0);
    chk("rst_rd", 32'(MEM_READ), 32'd0);
    chk("rst_wr", 32'(MEM_WRITE), 32'd0);
    chk("rst_addr", 32'(MEM_ADDR), 32'd0);
    chk("rst_wdata", 32'(MEM_WRITEDATA), 32'd0);
    chk("rst_halted", 32'(HALTED), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // kind: 0 = no memory access, 1 = read, 2 = write
  task automatic apply(input string nm, input logic [31:0] ins, input int nbusy,
                       input logic [7:0] rdat, input logic [31:0] exp_pc,
                       input int kind, input logic [7:0] ea, input logic [7:0] ewd);
    logic [31:0] pc_before;
    pc_before = PC;
    INSTRUCTION = ins;
    MEM_BUSYWAIT = 1'($urandom_range(0, 1));
    MEM_READDATA = 8'($urandom);
    @(posedge CLK);
    #1;
    if (kind == 0) begin
      chk({nm, "_pc"}, PC, exp_pc);
      chk({nm, "_noreq"}, 32'({MEM_READ, MEM_WRITE}), 32'd0);
    end else begin
      chk({nm, "_req"}, 32'({MEM_READ, MEM_WRITE}), (kind == 1) ? 32'd2 : 32'd1);
      chk({nm, "_addr"}, 32'(MEM_ADDR), 32'(ea));
      if (kind == 2) chk({nm, "_wdata"}, 32'(MEM_WRITEDATA), 32'(ewd));
      chk({nm, "_pchold"}, PC, pc_before);
      for (int k = 0; k < nbusy; k++) begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = 8'($urandom);
        @(posedge CLK);
        #1;
        chk({nm, "_busyreq"}, 32'({MEM_READ, MEM_WRITE}), (kind == 1) ? 32'd2 : 32'd1);
        chk({nm, "_busyaddr"}, 32'(MEM_ADDR), 32'(ea));
        chk({nm, "_busypc"}, PC, pc_before);
      end
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = rdat;
      @(posedge CLK);
      #1;
      chk({nm, "_donereq"}, 32'({MEM_READ, MEM_WRITE}), 32'd0);
      chk({nm, "_pc"}, PC, exp_pc);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          busy;
    logic [7:0]  rdat;
    logic [31:0] pc;
    int          kind;
    logic [7:0]  addr;
    logic [7:0]  wd;
  } vec_t;

  vec_t vt [26];

  // reference model state
  logic [7:0]  m_regs [8];
  logic [31:0] m_pc;

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET = 1'b1;
    INSTRUCTION = 32'hFF00_0000;
    MEM_READDATA = 8'h00;
    MEM_BUSYWAIT = 1'b0;
    instr16 = 32'hFF00_0000;
    rdata16 = 16'h0000;
    busy16 = 1'b0;

    vt[0]  = '{32'h0001_0005, 0, 8'h00, 32'd1,  0, 8'h00, 8'h00};
    vt[1]  = '{32'h0002_0003, 0, 8'h00, 32'd2,  0, 8'h00, 8'h00};
    vt[2]  = '{32'h0303_0102, 0, 8'h00, 32'd3,  0, 8'h00, 8'h00};
    vt[3]  = '{32'h0504_0102, 0, 8'h00, 32'd4,  0, 8'h00, 8'h00};
    vt[4]  = '{32'h0B00_0340, 0, 8'h00, 32'd5,  2, 8'h40, 8'h02};
    vt[5]  = '{32'h0B00_0441, 1, 8'h00, 32'd6,  2, 8'h41, 8'h07};
    vt[6]  = '{32'h0001_007F, 0, 8'h00, 32'd7,  0, 8'h00, 8'h00};
    vt[7]  = '{32'h0002_0002, 0, 8'h00, 32'd8,  0, 8'h00, 8'h00};
    vt[8]  = '{32'h0205_0102, 0, 8'h00, 32'd9,  0, 8'h00, 8'h00};
    vt[9]  = '{32'h0A00_0501, 0, 8'h00, 32'd10, 2, 8'h7F, 8'h81};
    vt[10] = '{32'h07FE_0101, 0, 8'h00, 32'd9,  0, 8'h00, 8'h00};
    vt[11] = '{32'h07FE_0102, 0, 8'h00, 32'd10, 0, 8'h00, 8'h00};
    vt[12] = '{32'h0603_0000, 0, 8'h00, 32'd14, 0, 8'h00, 8'h00};
    vt[13] = '{32'h0007_0010, 0, 8'h00, 32'd15, 0, 8'h00, 8'h00};
    vt[14] = '{32'h0802_0007, 2, 8'h5C, 32'd16, 1, 8'h10, 8'h00};
    vt[15] = '{32'h0B00_0200, 0, 8'h00, 32'd17, 2, 8'h00, 8'h5C};
    vt[16] = '{32'h0900_00F0, 0, 8'h33, 32'd18, 1, 8'hF0, 8'h00};
    vt[17] = '{32'h0A00_0007, 0, 8'h00, 32'd19, 2, 8'h10, 8'h33};
    vt[18] = '{32'h0001_00AA, 0, 8'h00, 32'd20, 0, 8'h00, 8'h00};
    vt[19] = '{32'h0B00_0120, 3, 8'h00, 32'd21, 2, 8'h20, 8'hAA};
    vt[20] = '{32'hFF00_0000, 0, 8'h00, 32'd22, 0, 8'h00, 8'h00};
    vt[21] = '{32'h0103_0002, 0, 8'h00, 32'd23, 0, 8'h00, 8'h00};
    vt[22] = '{32'h0B00_0301, 0, 8'h00, 32'd24, 2, 8'h01, 8'h5C};
    vt[23] = '{32'h0009_0011, 0, 8'h00, 32'd25, 0, 8'h00, 8'h00};
    vt[24] = '{32'h0B00_0902, 0, 8'h00, 32'd26, 2, 8'h02, 8'h11};
    vt[25] = '{32'h0D12_3456, 0, 8'h00, 32'd27, 0, 8'h00, 8'h00};

    // 16-bit instance: immediate sign extension
    do_reset();
    instr16 = 32'h0006_00FF;
    @(posedge CLK); #1;
    chk("w16_loadi_pc", pc16, 32'd1);
    instr16 = 32'h0B00_067F;
    @(posedge CLK); #1;
    chk("w16_swi_wr", 32'(wr16), 32'd1);
    chk("w16_swi_addr", 32'(addr16), 32'h0000_007F);
    chk("w16_swi_wdata", 32'(wdata16), 32'h0000_FFFF);
    @(posedge CLK); #1;
    chk("w16_swi_done", 32'(wr16), 32'd0);
    chk("w16_swi_pc", pc16, 32'd2);
    instr16 = 32'h0900_0080;
    @(posedge CLK); #1;
    chk("w16_lwi_rd", 32'(rd16), 32'd1);
    chk("w16_lwi_addr", 32'(addr16), 32'h0000_FF80);
    @(posedge CLK); #1;
    instr16 = 32'hFF00_0000;

    // directed table
    do_reset();
    for (int i = 0; i < 26; i++) begin
      apply($sformatf("tbl%0d", i), vt[i].instr, vt[i].busy, vt[i].rdat,
            vt[i].pc, vt[i].kind, vt[i].addr, vt[i].wd);
    end

    // PC wrap through a negative jump offset
    do_reset();
    apply("j_fwd", 32'h0603_0000, 0, 8'h00, 32'd4, 0, 8'h00, 8'h00);
    apply("j_wrap", 32'h06FA_0000, 0, 8'h00, 32'hFFFF_FFFF, 0, 8'h00, 8'h00);
    apply("pc_wrap", 32'hFF00_0000, 0, 8'h00, 32'd0, 0, 8'h00, 8'h00);

    // reset asserted during a load's busy wait
    do_reset();
    apply("rl_li7", 32'h0007_0010, 0, 8'h00, 32'd1, 0, 8'h00, 8'h00);
    INSTRUCTION = 32'h0802_0007;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = 8'h5C;
    @(posedge CLK); #1;
    chk("rl_req", 32'(MEM_READ), 32'd1);
    chk("rl_addr", 32'(MEM_ADDR), 32'h10);
    @(posedge CLK); #1;
    chk("rl_busy", 32'(MEM_READ), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("rl_drop", 32'(MEM_READ), 32'd0);
    chk("rl_pc", PC, 32'd0);
    @(negedge CLK);
    MEM_BUSYWAIT = 1'b0;
    RESET = 1'b1;
    apply("rl_r2", 32'h0B00_0200, 0, 8'h00, 32'd1, 2, 8'h00, 8'h00);

    // halt at PC=3, then reset releases it
    apply("h_li1", 32'h0001_0001, 0, 8'h00, 32'd2, 0, 8'h00, 8'h00);
    apply("h_li2", 32'h0002_0002, 0, 8'h00, 32'd3, 0, 8'h00, 8'h00);
    apply("h_halt", 32'h0C00_0000, 0, 8'h00, 32'd3, 0, 8'h00, 8'h00);
    chk("h_halted", 32'(HALTED), 32'd1);
    for (int k = 0; k < 20; k++) begin
      INSTRUCTION = (k % 2 == 0) ? 32'h0B00_0120 : 32'h0802_0007;
      MEM_BUSYWAIT = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      chk("h_pc", PC, 32'd3);
      chk("h_noreq", 32'({MEM_READ, MEM_WRITE}), 32'd0);
      chk("h_stay", 32'(HALTED), 32'd1);
    end
    do_reset();
    chk("h_rel_halted", 32'(HALTED), 32'd0);
    chk("h_rel_pc", PC, 32'd0);

    // randomized instructions against the architectural model
    do_reset();
    for (int r = 0; r < 8; r++) m_regs[r] = 8'h00;
    m_pc = 32'd0;
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  op, f_rd, f_rs1, f_rs2, a, b, rdat, ea, ewd;
      logic [31:0] sxo, nxt;
      logic [2:0]  d;
      int          kind, nb;
      op = 8'($urandom_range(0, 13));
      if (op == 8'h0C) op = 8'hE7;
      f_rd  = 8'($urandom);
      f_rs1 = 8'($urandom);
      f_rs2 = 8'($urandom);
      a = m_regs[f_rs1[2:0]];
      b = m_regs[f_rs2[2:0]];
      d = f_rd[2:0];
      sxo = {{24{f_rd[7]}}, f_rd};
      kind = 0;
      ea = 8'h00;
      ewd = 8'h00;
      nb = $urandom_range(0, 3);
      rdat = 8'($urandom);
      nxt = m_pc + 32'd1;
      case (op)
        8'h00: m_regs[d] = f_rs2;
        8'h01: m_regs[d] = b;
        8'h02: m_regs[d] = a + b;
        8'h03: m_regs[d] = a - b;
        8'h04: m_regs[d] = a & b;
        8'h05: m_regs[d] = a | b;
        8'h06: nxt = m_pc + 32'd1 + sxo;
        8'h07: if (a == b) nxt = m_pc + 32'd1 + sxo;
        8'h08: begin kind = 1; ea = b;     m_regs[d] = rdat; end
        8'h09: begin kind = 1; ea = f_rs2; m_regs[d] = rdat; end
        8'h0A: begin kind = 2; ea = b;     ewd = a; end
        8'h0B: begin kind = 2; ea = f_rs2; ewd = a; end
        default: ;
      endcase
      apply($sformatf("rnd%0d_op%0h", n, op), {op, f_rd, f_rs1, f_rs2}, nb, rdat,
            nxt, kind, ea, ewd);
      m_pc = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
